multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle RV32I datapath. Sequences fetch, decode, execute, memory and writeback over a shared single-port memory.
- Consumes opcode/funct3/funct7 from the decode stage and the branch comparator result.
- Drives register/PC/IR enables, ALU operand and operation selects, immediate-type select, and a req/ack memory handshake.
- Keeps a retired-instruction counter and a sticky illegal-instruction trap.

---
 rtl/rv_pkg.sv | 52 +++++
 rtl/imm_sel_dec.sv | 22 ++
 rtl/multicycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the multicycle RV32I control path: opcodes, FSM states
// and the encodings of every datapath select driven by the controller.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEM_ADDR,
        MEM_RD,
        MEM_WR,
        WB_ALU,
        WB_MEM,
        BRANCH,
        JAL,
        TRAP
    } state_t;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;

    localparam logic [1:0] ALU_ADD      = 2'b00;
    localparam logic [1:0] ALU_SUB      = 2'b01;
    localparam logic [1:0] ALU_FUNCT    = 2'b10;

    localparam logic [1:0] RES_ALUOUT   = 2'b00;
    localparam logic [1:0] RES_MEM      = 2'b01;
    localparam logic [1:0] RES_ALU      = 2'b10;
    localparam logic [1:0] RES_PC       = 2'b11;

    localparam logic [2:0] IMM_I        = 3'd0;
    localparam logic [2:0] IMM_S        = 3'd1;
    localparam logic [2:0] IMM_B        = 3'd2;
    localparam logic [2:0] IMM_J        = 3'd3;
    localparam logic [2:0] IMM_U        = 3'd4;

endpackage

// File: rtl/imm_sel_dec.sv
// Immediate-format select, decoded straight from the opcode so the immediate
// generator is ready in DECODE without waiting on the FSM.
module imm_sel_dec
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_sel
);

    always_comb begin
        imm_sel = IMM_I;
        case (opcode)
            OP_LOAD, OP_IMM: imm_sel = IMM_I;
            OP_STORE:        imm_sel = IMM_S;
            OP_BRANCH:       imm_sel = IMM_B;
            OP_JAL:          imm_sel = IMM_J;
            OP_LUI:          imm_sel = IMM_U;
            default:         imm_sel = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I datapath: sequences the shared memory
// port, datapath selects and enables, and tracks retired count and illegal trap.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 on ack
// DECODE   | ALUOut <= old_pc+imm, dispatch on opcode
// EXEC_R   | rs1 op rs2
// EXEC_I   | rs1 op imm (0 + imm for LUI)
// MEM_ADDR | ALUOut <= rs1+imm
// MEM_RD   | load request at ALUOut, wait for ack
// MEM_WR   | store request at ALUOut, wait for ack, retire
// WB_ALU   | rd <= ALUOut, retire
// WB_MEM   | rd <= mem data, retire
// BRANCH   | compare, PC <= ALUOut if taken, retire
// JAL      | rd <= PC, PC <= ALUOut, retire
// TRAP     | illegal instruction, held until reset
module multicycle_ctrl
    import rv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             branch_cond,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_sel,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t           state;
    state_t           state_nx;
    logic             illegal_q;
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    // funct fields are decoded by the ALU control, not here
    logic unused_funct;
    assign unused_funct = ^{funct3, funct7};

    imm_sel_dec u_imm_sel_dec (
        .opcode  (opcode),
        .imm_sel (imm_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:    if (mem_ack) state_nx = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:              state_nx = EXEC_R;
                    OP_IMM, OP_LUI:    state_nx = EXEC_I;
                    OP_LOAD, OP_STORE: state_nx = MEM_ADDR;
                    OP_BRANCH:         state_nx = BRANCH;
                    OP_JAL:            state_nx = JAL;
                    default:           state_nx = TRAP;
                endcase
            end
            EXEC_R:   state_nx = WB_ALU;
            EXEC_I:   state_nx = WB_ALU;
            MEM_ADDR: state_nx = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ack) state_nx = WB_MEM;
            MEM_WR:   if (mem_ack) state_nx = FETCH;
            WB_ALU:   state_nx = FETCH;
            WB_MEM:   state_nx = FETCH;
            BRANCH:   state_nx = FETCH;
            JAL:      state_nx = FETCH;
            TRAP:     state_nx = TRAP;
            default:  state_nx = FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        // reset masks the current state so a pending request drops immediately
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    ir_write  = mem_ack;
                    pc_write  = mem_ack;
                end
                DECODE: begin
                    alu_src_a = SRC_A_OLD_PC;
                    alu_src_b = SRC_B_IMM;
                end
                EXEC_R: begin
                    alu_src_a = SRC_A_RS1;
                    alu_op    = ALU_FUNCT;
                end
                EXEC_I: begin
                    alu_src_a = (opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = (opcode == OP_LUI) ? ALU_ADD : ALU_FUNCT;
                end
                MEM_ADDR: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                end
                MEM_RD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                end
                WB_ALU: begin
                    reg_write  = 1'b1;
                    result_src = RES_ALUOUT;
                end
                WB_MEM: begin
                    reg_write  = 1'b1;
                    result_src = RES_MEM;
                end
                BRANCH: begin
                    alu_src_a = SRC_A_RS1;
                    alu_op    = ALU_SUB;
                    pc_src    = 1'b1;
                    pc_write  = branch_cond;
                end
                JAL: begin
                    reg_write  = 1'b1;
                    result_src = RES_PC;
                    pc_write   = 1'b1;
                    pc_src     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign retire = (state_nx == FETCH) && (state != FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            if (state_nx == TRAP) illegal_q <= 1'b1;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its
// expected per-cycle output sequence from the instruction class and ack stalls.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_IMM    = 7'b0010011;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;

    // enable bits of the packed output vector: req, we, ir_write, pc_write, reg_write
    localparam logic [14:0] EN_MASK = 15'h6D00;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = 7'd0;
    logic [2:0]    funct3 = 3'd0;
    logic [6:0]    funct7 = 7'd0;
    logic          branch_cond = 1'b0;
    logic          mem_ack = 1'b0;
    logic          mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write;
    logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0]    imm_sel;
    logic          illegal;
    logic [CW-1:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .branch_cond (branch_cond),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .imm_sel     (imm_sel),
        .illegal     (illegal),
        .instret     (instret)
    );

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         retired = 0;
    logic       m_illegal = 1'b0;
    logic [6:0] cur_op = 7'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            T_LOAD, T_IMM: return 3'd0;
            T_STORE:       return 3'd1;
            T_BRANCH:      return 3'd2;
            T_JAL:         return 3'd3;
            T_LUI:         return 3'd4;
            default:       return 3'd0;
        endcase
    endfunction

    function automatic logic [14:0] pk(input logic req, input logic we, input logic adr,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic rw, input logic [1:0] rs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] op);
        return {req, we, adr, irw, pcw, pcs, rw, rs, a, b, op};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return (op == T_R) || (op == T_IMM) || (op == T_LUI) || (op == T_LOAD) ||
               (op == T_STORE) || (op == T_BRANCH) || (op == T_JAL);
    endfunction

    // one clock cycle: drive inputs after the edge, compare mid-cycle
    task automatic step(input string tag, input logic ack, input logic bc,
                        input logic [14:0] exp, input logic in_rst);
        logic [14:0] obs;
        @(posedge clk);
        #1;
        rst         = in_rst;
        mem_ack     = ack;
        branch_cond = bc;
        opcode      = cur_op;
        funct3      = 3'($urandom);
        funct7      = 7'($urandom);
        #3;
        cyc++;
        obs = {mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op};
        if (in_rst) begin
            check({tag, "_en"}, 32'(obs & EN_MASK), 32'd0);
        end else begin
            check(tag, 32'(obs), 32'(exp));
            check({tag, "_illegal"}, 32'(illegal), 32'(m_illegal));
        end
        check({tag, "_imm"}, 32'(imm_sel), 32'(imm_of(cur_op)));
        check({tag, "_instret"}, 32'(instret), 32'(retired % (1 << CW)));
    endtask

    task automatic do_reset(input logic ack);
        step("reset", ack, rb(), 15'd0, 1'b1);
        retired   = 0;
        m_illegal = 1'b0;
    endtask

    task automatic fetch_decode(input int fs);
        for (int i = 0; i <= fs; i++) begin
            logic a;
            a = (i == fs);
            step("fetch", a, rb(), pk(1, 0, 0, a, a, 0, 0, 2'd0, 2'd0, 2'd2, 2'd0), 1'b0);
        end
        step("decode", rb(), rb(), pk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 2'd0), 1'b0);
    endtask

    // bcv < 0 picks a random branch outcome
    task automatic run_instr(input logic [6:0] op, input int fs, input int ms, input int bcv);
        logic bc;
        cur_op = op;
        fetch_decode(fs);
        case (op)
            T_R: begin
                step("exec_r", rb(), rb(), pk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd2), 1'b0);
                step("wb_alu", rb(), rb(), pk(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0), 1'b0);
                retired++;
            end
            T_IMM, T_LUI: begin
                if (op == T_LUI)
                    step("exec_lui", rb(), rb(), pk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd1, 2'd0), 1'b0);
                else
                    step("exec_i", rb(), rb(), pk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd2), 1'b0);
                step("wb_alu", rb(), rb(), pk(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0), 1'b0);
                retired++;
            end
            T_LOAD, T_STORE: begin
                step("mem_addr", rb(), rb(), pk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0), 1'b0);
                for (int i = 0; i <= ms; i++) begin
                    if (op == T_LOAD)
                        step("mem_rd", (i == ms), rb(), pk(1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0), 1'b0);
                    else
                        step("mem_wr", (i == ms), rb(), pk(1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0), 1'b0);
                end
                if (op == T_LOAD)
                    step("wb_mem", rb(), rb(), pk(0, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 2'd0), 1'b0);
                retired++;
            end
            T_BRANCH: begin
                bc = (bcv < 0) ? rb() : 1'(bcv);
                step("branch", rb(), bc, pk(0, 0, 0, 0, bc, 1, 0, 2'd0, 2'd2, 2'd0, 2'd1), 1'b0);
                retired++;
            end
            T_JAL: begin
                step("jal", rb(), rb(), pk(0, 0, 0, 0, 1, 1, 1, 2'd3, 2'd0, 2'd0, 2'd0), 1'b0);
                retired++;
            end
            default: begin
                m_illegal = 1'b1;
                for (int i = 0; i < 10; i++)
                    step("trap", rb(), rb(), 15'd0, 1'b0);
            end
        endcase
    endtask

    initial begin
        logic [6:0] legal_ops [7];
        logic [6:0] bad_op;
        legal_ops = '{T_R, T_IMM, T_LUI, T_LOAD, T_STORE, T_BRANCH, T_JAL};

        do_reset(1'b1);
        do_reset(1'b0);

        // directed: add, lw with double stalls, taken/not-taken beq, jal
        run_instr(T_R, 0, 0, -1);
        run_instr(T_LOAD, 2, 2, -1);
        run_instr(T_BRANCH, 0, 0, 1);
        run_instr(T_BRANCH, 0, 0, 0);
        run_instr(T_JAL, 0, 0, -1);
        run_instr(T_LUI, 1, 0, -1);
        run_instr(T_STORE, 0, 1, -1);

        // random legal stream, long enough to wrap the narrow counter
        for (int n = 0; n < 40; n++)
            run_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 3), -1);

        run_instr(7'b1111111, 0, 0, -1);
        do_reset(1'b1);
        run_instr(T_IMM, 0, 0, -1);

        // reset in the middle of a store stall, with ack arriving in the reset cycle
        cur_op = T_STORE;
        fetch_decode(0);
        step("mem_addr", rb(), rb(), pk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0), 1'b0);
        step("mem_wr", 1'b0, rb(), pk(1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0), 1'b0);
        do_reset(1'b1);
        run_instr(T_R, 1, 0, -1);

        bad_op = 7'h7F;
        for (int t = 0; t < 100; t++) begin
            bad_op = 7'($urandom);
            if (!is_legal(bad_op)) break;
        end
        if (is_legal(bad_op)) bad_op = 7'h7F;
        run_instr(bad_op, $urandom_range(0, 2), 0, -1);
        do_reset(1'b0);
        run_instr(T_JAL, 0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
